// File: rtl/result_ascii_encoder.sv
// ============================================================================
// Module   : result_ascii_encoder
// Purpose  : Converts a signed ALU result (or an error flag) into an ASCII
//            decimal string and streams it byte-by-byte to the UART TX.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module result_ascii_encoder #(
    parameter int         WIDTH    = 16,
    parameter int         DIGITS   = 5,
    parameter logic [7:0] TERM     = 8'h0D,
    parameter logic [7:0] ERR_CHAR = 8'h45,
    parameter logic [7:0] MINUS    = 8'h2D
) (
    input  logic             i_clk,
    input  logic             reset,
    input  logic             i_ready,
    input  logic [WIDTH-1:0] i_result,
    input  logic             i_err,
    input  logic             i_tx_ready,
    output logic [7:0]       o_data,
    output logic             o_valid,
    output logic             o_busy,
    output logic             o_done
);

    localparam int c_BCD_W = 4 * DIGITS;
    localparam int c_IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int c_CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CONVERT   = 3'd1,
        ST_EMIT_SIGN = 3'd2,
        ST_EMIT_DIG  = 3'd3,
        ST_EMIT_ERR  = 3'd4,
        ST_EMIT_TERM = 3'd5,
        ST_DONE      = 3'd6
    } state_t;

    state_t               r_state, w_state_nxt;
    logic                 r_neg, w_neg_nxt;
    logic [WIDTH-1:0]     r_mag, w_mag_nxt;
    logic [c_BCD_W-1:0]   r_bcd, w_bcd_nxt;
    logic [c_CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [c_IDX_W-1:0]   r_idx, w_idx_nxt;
    logic [7:0]           r_data, w_data_nxt;
    logic                 r_valid, w_valid_nxt;
    logic                 r_busy, w_busy_nxt;
    logic                 r_done, w_done_nxt;

    logic [WIDTH-1:0]     w_mag_in;
    logic [c_BCD_W-1:0]   w_bcd_shift;
    logic [DIGITS-1:0]    w_carry;
    logic [c_IDX_W-1:0]   w_lead;
    logic [3:0]           w_nib;
    logic                 w_can_emit;

    assign w_mag_in   = i_result[WIDTH-1] ? (~i_result + WIDTH'(1)) : i_result;
    assign w_nib      = r_bcd[{r_idx, 2'b00} +: 4];
    // Mandatory idle cycle between bytes: never emit right after an emit.
    assign w_can_emit = i_tx_ready && !r_valid;

    // One double-dabble step: add-3 correction per nibble, then shift left by one.
    assign w_carry[0] = r_mag[WIDTH-1];
    for (genvar k = 0; k < DIGITS; k++) begin : g_add3
        logic [3:0] w_n;
        assign w_n = r_bcd[4*k +: 4];
        if (k == DIGITS - 1) begin : g_top
            logic [2:0] w_a;
            assign w_a = (w_n >= 4'd5) ? (w_n[2:0] + 3'd3) : w_n[2:0];
            assign w_bcd_shift[4*k +: 4] = {w_a, w_carry[k]};
        end else begin : g_low
            logic [3:0] w_a;
            assign w_a = (w_n >= 4'd5) ? (w_n + 4'd3) : w_n;
            assign w_bcd_shift[4*k +: 4] = {w_a[2:0], w_carry[k]};
            assign w_carry[k+1]          = w_a[3];
        end
    end

    // Most-significant nonzero digit of the final BCD value; zero maps to digit 0.
    always_comb begin
        w_lead = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (w_bcd_shift[4*k +: 4] != 4'd0) w_lead = c_IDX_W'(k);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_neg_nxt   = r_neg;
        w_mag_nxt   = r_mag;
        w_bcd_nxt   = r_bcd;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_data_nxt  = r_data;
        w_valid_nxt = 1'b0;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_ready) begin
                    w_busy_nxt  = 1'b1;
                    w_neg_nxt   = !i_err && i_result[WIDTH-1];
                    w_mag_nxt   = w_mag_in;
                    w_bcd_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_state_nxt = i_err ? ST_EMIT_ERR : ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                w_mag_nxt = {r_mag[WIDTH-2:0], 1'b0};
                w_bcd_nxt = w_bcd_shift;
                w_cnt_nxt = r_cnt + c_CNT_W'(1);
                if (r_cnt == c_CNT_W'(WIDTH - 1)) begin
                    w_idx_nxt   = w_lead;
                    w_state_nxt = r_neg ? ST_EMIT_SIGN : ST_EMIT_DIG;
                end
            end
            ST_EMIT_SIGN: begin
                if (w_can_emit) begin
                    w_data_nxt  = MINUS;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = ST_EMIT_DIG;
                end
            end
            ST_EMIT_DIG: begin
                if (w_can_emit) begin
                    w_data_nxt  = 8'h30 + {4'h0, w_nib};
                    w_valid_nxt = 1'b1;
                    if (r_idx == '0) w_state_nxt = ST_EMIT_TERM;
                    else             w_idx_nxt   = r_idx - c_IDX_W'(1);
                end
            end
            ST_EMIT_ERR: begin
                if (w_can_emit) begin
                    w_data_nxt  = ERR_CHAR;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = ST_EMIT_TERM;
                end
            end
            ST_EMIT_TERM: begin
                if (w_can_emit) begin
                    w_data_nxt  = TERM;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                // First DONE cycle carries the TERM pulse; second raises o_done.
                if (!r_done) begin
                    w_done_nxt = 1'b1;
                end else begin
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_neg   <= 1'b0;
            r_mag   <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_data  <= 8'h00;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_neg   <= w_neg_nxt;
            r_mag   <= w_mag_nxt;
            r_bcd   <= w_bcd_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;
    assign o_busy  = r_busy;
    assign o_done  = r_done;

endmodule

`default_nettype wire

// File: doc/result_ascii_encoder.md
Name: result_ascii_encoder

Overview:
Transmit-side counterpart of the ASCII operator decoder on the UART input path. Accepts a finished signed ALU result, or an error flag, and converts it to an ASCII decimal string. Streams the string one byte at a time to the UART transmitter under a ready/valid-pulse handshake. Sits between the ALU result register and the UART TX byte interface.

Parameters:
WIDTH, 16, result width in bits (two's complement)
DIGITS, 5, decimal digit slots; must hold 2^(WIDTH-1) (5 for WIDTH=16)
TERM, 8'h0D, terminator byte appended to every string
ERR_CHAR, 8'h45, byte sent instead of digits when i_err=1 ('E')
MINUS, 8'h2D, sign byte for negative results ('-')

Ports:
i_clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
i_ready  in  1  start pulse; samples i_result/i_err when block idle
i_result  in  WIDTH  signed result to print
i_err  in  1  error flag (e.g. divide by zero), sampled with i_ready
i_tx_ready  in  1  UART TX can accept a byte this cycle
o_data  out  8  ASCII byte, valid in the cycle o_valid=1
o_valid  out  1  one-cycle pulse per emitted byte
o_busy  out  1  high from cycle after accepted i_ready until o_done cycle inclusive
o_done  out  1  one-cycle pulse in the cycle after the TERM byte is emitted

Behaviour:
- Reset (sync, active-high; i_clk): state IDLE; o_data=0, o_valid=0, o_busy=0, o_done=0; digit/shift registers cleared. Reset mid-string aborts immediately: no further o_valid; all outputs 0 on the next edge.
- States: IDLE, CONVERT, EMIT_SIGN, EMIT_DIG, EMIT_ERR, EMIT_TERM, DONE.
- IDLE: on i_ready=1, capture i_err, sign bit and magnitude. Magnitude = |i_result| as WIDTH-bit unsigned, so 16'h8000 gives 32768. Set o_busy.
  - i_err=1: go to EMIT_ERR; i_result is ignored.
  - i_err=0: go to CONVERT.
- i_ready while o_busy=1 is ignored (no queueing).
- CONVERT: double-dabble, one shift (with add-3 correction) per cycle, exactly WIDTH cycles, into DIGITS BCD nibbles.
  - Then go to EMIT_SIGN if negative, else EMIT_DIG.
  - Leading-zero index = first nonzero nibble from the MS side; value 0 emits a single '0'.
- Emit rule, all EMIT_* states:
  - A byte is emitted in a cycle where i_tx_ready=1 and no byte was emitted in the previous cycle (mandatory one-cycle gap). o_valid=1 and o_data=byte in that cycle.
  - If i_tx_ready=0, the state holds indefinitely with o_valid=0; o_data holds its last value.
- EMIT_SIGN: emit MINUS, then go to EMIT_DIG.
- EMIT_DIG: emit 8'h30+nibble, MS significant digit first, down to the LS digit, then go to EMIT_TERM.
- EMIT_ERR: emit ERR_CHAR, then go to EMIT_TERM.
- EMIT_TERM: emit TERM, then go to DONE.
- DONE: o_done=1 for one cycle, o_busy=0 on the next edge, return to IDLE. An i_ready in the DONE cycle is ignored; one in the following cycle is accepted.
- Latency, start to first byte (i_tx_ready held 1): i_ready at edge N, CONVERT edges N+1..N+WIDTH, first o_valid at cycle N+WIDTH+1.
  - Error path: first o_valid at N+1.
- Byte count per string: sign(0/1) + digits(1..DIGITS) + 1, or 2 for error. No other bytes are emitted.
- o_valid is never high in IDLE, CONVERT or DONE.

Test Plan:
- i_result=16'd0, i_err=0, i_tx_ready=1 -> bytes 0x30, 0x0D on alternate cycles; first o_valid 17 cycles after i_ready; o_done one cycle after 0x0D.
- i_result=16'd1234 -> 0x31,0x32,0x33,0x34,0x0D; exactly 5 o_valid pulses, each followed by a gap cycle.
- i_result=16'hFFF9 (-7) -> 0x2D,0x37,0x0D. i_result=16'h8000 -> 0x2D,0x33,0x32,0x37,0x36,0x38,0x0D. i_result=16'h7FFF -> 0x33,0x32,0x37,0x36,0x37,0x0D.
- i_err=1, i_result=16'd55, i_tx_ready=0 for 10 cycles then 1 -> no o_valid while low; then 0x45, 0x0D; o_busy high throughout until o_done.
- Second i_ready pulse during EMIT_DIG of 16'd99 -> output stays 0x39,0x39,0x0D; no second string.
- reset asserted after 2 bytes of 16'd1234 -> next edge: o_valid=0, o_busy=0, o_data=0, no further bytes. A later i_ready with 16'd5 -> 0x35,0x0D.
